// File: rtl/qbus_dma_arb.sv
// Round-robin DMA arbiter for the vm2 QBUS: collects requests from NREQ on-chip
// masters, runs the DMR/DMGO/SACK handshake with the CPU and grants the bus to
// one master at a time once no CPU cycle is in flight.
module qbus_dma_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TMO      = 1024,
  parameter int unsigned HOLD_MAX = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] done_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            own_o,
  output logic            err_o,
  output logic            qb_dmr_n,
  output logic            qb_sack_n,
  input  logic            qb_dmgo_n,
  input  logic            qb_sync_n,
  input  logic            qb_rply_n
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TMO);
  localparam int unsigned HW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_IDLE,
    S_OWN,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic            dmgo_s, sync_s, rply_s;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, win_idx, cand;
  logic            win_found;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            own_q, own_d, err_q, err_d;
  logic            dmr_n_q, dmr_n_d, sack_n_q, sack_n_d;
  logic            hold_rel, rel;

  // Bus control lines are asynchronous to wb_clk_i: two-stage synchronizers
  always_comb begin
    sync1_d = {qb_dmgo_n, qb_sync_n, qb_rply_n};
    sync2_d = sync1_q;
  end

  assign dmgo_s = ~sync2_q[2];
  assign sync_s = ~sync2_q[1];
  assign rply_s = ~sync2_q[0];

  // Round-robin pick: first requester at or above ptr, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = PW'((int'(ptr_q) + i) % int'(NREQ));
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic for the DMA handshake
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    tcnt_d   = tcnt_q;
    hcnt_d   = hcnt_q;
    gnt_d    = gnt_q;
    own_d    = own_q;
    err_d    = 1'b0;
    dmr_n_d  = dmr_n_q;
    sack_n_d = sack_n_q;
    hold_rel = 1'b0;
    rel      = 1'b0;

    case (state_q)
      S_IDLE: begin
        dmr_n_d  = 1'b1;
        sack_n_d = 1'b1;
        gnt_d    = '0;
        own_d    = 1'b0;
        if (win_found) begin
          win_d   = win_idx;
          dmr_n_d = 1'b0;
          tcnt_d  = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        tcnt_d = tcnt_q + TW'(1);
        if (dmgo_s) begin
          state_d = S_WAIT_IDLE;
        end else if (!req_i[win_q]) begin
          dmr_n_d = 1'b1;
          state_d = S_RELEASE;
        end else if (tcnt_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          dmr_n_d = 1'b1;
          state_d = S_RELEASE;
        end
      end

      S_WAIT_IDLE: begin
        if (!sync_s && !rply_s) begin
          sack_n_d     = 1'b0;
          dmr_n_d      = 1'b1;
          gnt_d        = '0;
          gnt_d[win_q] = 1'b1;
          own_d        = 1'b1;
          hcnt_d       = '0;
          state_d      = S_OWN;
        end
      end

      S_OWN: begin
        if (hcnt_q != {HW{1'b1}}) hcnt_d = hcnt_q + HW'(1);
        // Forced hand-back only between transactions, never mid-cycle
        hold_rel = (HOLD_MAX != 0) && (hcnt_q >= HW'(HOLD_MAX)) && !sync_s;
        rel      = done_i[win_q] || !req_i[win_q] || hold_rel;
        if (rel) begin
          gnt_d    = '0;
          own_d    = 1'b0;
          sack_n_d = 1'b1;
          ptr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_d  = S_RELEASE;
        end
      end

      S_RELEASE: begin
        dmr_n_d  = 1'b1;
        sack_n_d = 1'b1;
        if (!dmgo_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      ptr_q    <= '0;
      win_q    <= '0;
      tcnt_q   <= '0;
      hcnt_q   <= '0;
      gnt_q    <= '0;
      own_q    <= 1'b0;
      err_q    <= 1'b0;
      dmr_n_q  <= 1'b1;
      sack_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      tcnt_q   <= tcnt_d;
      hcnt_q   <= hcnt_d;
      gnt_q    <= gnt_d;
      own_q    <= own_d;
      err_q    <= err_d;
      dmr_n_q  <= dmr_n_d;
      sack_n_q <= sack_n_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign own_o     = own_q;
  assign err_o     = err_q;
  assign qb_dmr_n  = dmr_n_q;
  assign qb_sack_n = sack_n_q;

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Directed bench for qbus_dma_arb (NREQ=4, TMO=16, HOLD_MAX=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_qbus_dma_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, done, gnt;
  logic       own, err, dmr_n, sack_n;
  logic       dmgo_n, sync_n, rply_n;
  logic       mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  qbus_dma_arb #(.NREQ(4), .TMO(16), .HOLD_MAX(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .own_o    (own),
    .err_o    (err),
    .qb_dmr_n (dmr_n),
    .qb_sack_n(sack_n),
    .qb_dmgo_n(dmgo_n),
    .qb_sync_n(sync_n),
    .qb_rply_n(rply_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for the arbiter to raise DMR toward the CPU
  task automatic wait_dmr(input string tag);
    int n = 0;
    while (dmr_n !== 1'b0 && n < 12) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(dmr_n), 32'd0);
  endtask

  // CPU grants the bus right after DMR; quiet bus means grant 4 cycles later
  task automatic own_bus(input string tag, input logic [3:0] exp);
    dmgo_n = 1'b0;
    tick(3);
    chk({tag, "_pre_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_pre_sack"}, 32'(sack_n), 32'd1);
    tick(1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp));
    chk({tag, "_sack"}, 32'(sack_n), 32'd0);
    chk({tag, "_dmr"}, 32'(dmr_n), 32'd1);
    dmgo_n = 1'b1;
  endtask

  // Invariants: one-hot grant, SACK tracks grant, own_o = |gnt_o
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", 32'($onehot0(gnt)), 32'd1);
      chk("sack_vs_gnt", 32'(gnt != 4'b0), 32'(!sack_n));
      chk("own_vs_gnt", 32'(own), 32'(|gnt));
    end
  end

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; req = '0; done = '0;
    dmgo_n = 1'b1; sync_n = 1'b1; rply_n = 1'b1;
    tick(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_own", 32'(own), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dmr", 32'(dmr_n), 32'd1);
    chk("rst_sack", 32'(sack_n), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(1);

    // 1) single request, DMGO 5 cycles after DMR
    req = 4'b0010;
    tick(1);
    chk("t1_dmr", 32'(dmr_n), 32'd0);
    tick(4);
    chk("t1_nogrant", 32'(gnt), 32'd0);
    own_bus("t1", 4'b0010);
    tick(2);
    chk("t1_hold", 32'(gnt), 32'h2);
    done = 4'b0010; req = 4'b0000;
    tick(1);
    done = '0;
    chk("t1_rel_gnt", 32'(gnt), 32'd0);
    chk("t1_rel_sack", 32'(sack_n), 32'd1);
    tick(3);
    chk("t1_idle_dmr", 32'(dmr_n), 32'd1);
    // ptr is now 2: with 0110 pending master 2 wins, not master 1
    req = 4'b0110;
    tick(1);
    chk("t1b_dmr", 32'(dmr_n), 32'd0);
    own_bus("t1b", 4'b0100);
    done = 4'b0100; req = 4'b0000;
    tick(1);
    done = '0;
    chk("t1b_rel", 32'(gnt), 32'd0);
    tick(4);

    // 2) all four request continuously; round robin from ptr 0
    rst = 1'b1; tick(1); rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_dmr($sformatf("t2_dmr%0d", k));
      own_bus($sformatf("t2_own%0d", k), order[k]);
      tick(2);
      chk($sformatf("t2_hold%0d", k), 32'(gnt), 32'(order[k]));
      done = order[k];
      tick(1);
      done = '0;
      chk($sformatf("t2_rel%0d", k), 32'(gnt), 32'd0);
    end
    req = '0;
    rst = 1'b1; tick(1); rst = 1'b0;

    // 3) DMGO never comes: abort after TMO cycles, ptr unchanged
    req = 4'b0001;
    tick(1);
    chk("t3_dmr", 32'(dmr_n), 32'd0);
    tick(15);
    chk("t3_no_err_yet", 32'(err), 32'd0);
    chk("t3_dmr_held", 32'(dmr_n), 32'd0);
    tick(1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_dmr_drop", 32'(dmr_n), 32'd1);
    chk("t3_gnt", 32'(gnt), 32'd0);
    req = 4'b0011;
    tick(1);
    chk("t3_err_pulse", 32'(err), 32'd0);
    chk("t3_release_dmr", 32'(dmr_n), 32'd1);
    tick(1);
    chk("t3_retry_dmr", 32'(dmr_n), 32'd0);
    own_bus("t3", 4'b0001);
    done = 4'b0001; req = 4'b0000;
    tick(1);
    done = '0;
    chk("t3_rel", 32'(gnt), 32'd0);
    tick(4);

    // 4) grant deferred while SYNC and then RPLY are still active
    req = 4'b0100;
    tick(1);
    chk("t4_dmr", 32'(dmr_n), 32'd0);
    dmgo_n = 1'b0; sync_n = 1'b0; rply_n = 1'b0;
    tick(10);
    chk("t4_busy_gnt", 32'(gnt), 32'd0);
    chk("t4_busy_sack", 32'(sack_n), 32'd1);
    chk("t4_busy_dmr", 32'(dmr_n), 32'd0);
    sync_n = 1'b1;
    tick(2);
    chk("t4_rply_busy", 32'(gnt), 32'd0);
    rply_n = 1'b1;
    tick(2);
    chk("t4_sync_lag", 32'(gnt), 32'd0);
    tick(1);
    chk("t4_gnt", 32'(gnt), 32'h4);
    chk("t4_sack", 32'(sack_n), 32'd0);
    dmgo_n = 1'b1;
    done = 4'b0100; req = 4'b0000;
    tick(1);
    done = '0;
    chk("t4_rel", 32'(gnt), 32'd0);
    tick(4);

    // 5) HOLD_MAX forced hand-back waits for SYNC to clear
    req = 4'b0011;
    tick(1);
    chk("t5_dmr", 32'(dmr_n), 32'd0);
    own_bus("t5", 4'b0001);
    done = 4'b0010;
    tick(1);
    done = '0;
    chk("t5_foreign_done", 32'(gnt), 32'h1);
    tick(4);
    chk("t5_g5", 32'(gnt), 32'h1);
    sync_n = 1'b0;
    tick(4);
    chk("t5_sync_blocks", 32'(gnt), 32'h1);
    sync_n = 1'b1;
    tick(2);
    chk("t5_sync_lag", 32'(gnt), 32'h1);
    tick(1);
    chk("t5_hold_rel", 32'(gnt), 32'd0);
    wait_dmr("t5_dmr1");
    own_bus("t5_m1", 4'b0010);
    req = 4'b0000;
    tick(1);
    chk("t5_withdraw", 32'(gnt), 32'd0);
    tick(4);

    // 7) request withdrawn before DMGO: no grant, ptr stays at 2
    req = 4'b1000;
    tick(1);
    chk("t7_dmr", 32'(dmr_n), 32'd0);
    req = 4'b0000;
    tick(1);
    chk("t7_dmr_drop", 32'(dmr_n), 32'd1);
    chk("t7_err", 32'(err), 32'd0);
    req = 4'b1001;
    wait_dmr("t7_redmr");
    own_bus("t7", 4'b1000);

    // 6) reset while a master owns the bus
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_sack", 32'(sack_n), 32'd1);
    chk("t6_dmr", 32'(dmr_n), 32'd1);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_own", 32'(own), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("t6_idle_dmr", 32'(dmr_n), 32'd0);
    own_bus("t6", 4'b0001);
    done = 4'b0001; req = 4'b0000;
    tick(1);
    done = '0;
    chk("t6_rel", 32'(gnt), 32'd0);
    tick(4);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
